// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, iteration count and
// the DIV/DIVU funct codes it serves.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_CYCLES = 32;

    localparam logic [5:0] EXE_DIV  = 6'b011010;
    localparam logic [5:0] EXE_DIVU = 6'b011011;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring shift-subtract iteration on unsigned magnitudes.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   prem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   prem_nxt,
    output logic [WIDTH-1:0] dvd_nxt
);

    logic [WIDTH+1:0] diff;
    logic             ge;

    // prem never exceeds the divisor, so its top bit is zero and the extra
    // diff bit acts purely as the borrow of the trial subtraction.
    assign diff     = {prem, dvd[WIDTH-1]} - {2'b00, dvs};
    assign ge       = ~diff[WIDTH+1];
    assign prem_nxt = ge ? diff[WIDTH:0] : {prem[WIDTH-1:0], dvd[WIDTH-1]};
    assign dvd_nxt  = {dvd[WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: stalls EX while iterating, then presents
// quotient (LO) and remainder (HI) for a single done cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   prem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             last;

    assign a_neg = signed_div & a[WIDTH-1];
    assign b_neg = signed_div & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;
    assign last  = (cnt == CW'(WIDTH - 1));

    // Sign fix-up is applied to the outputs of the final step directly.
    assign q_fix = neg_q ? -dvd_nxt : dvd_nxt;
    assign r_fix = neg_r ? -prem_nxt[WIDTH-1:0] : prem_nxt[WIDTH-1:0];

    assign stall_req = ~rst & (((state == DIV_IDLE) & start & ~cancel) |
                               (state == DIV_CALC));

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .prem     (prem),
        .dvd      (dvd),
        .dvs      (dvs),
        .prem_nxt (prem_nxt),
        .dvd_nxt  (dvd_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            prem      <= '0;
            dvd       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= DIV_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start) begin
                            if (b == '0) begin
                                quotient  <= '1;
                                remainder <= a;
                                done      <= 1'b1;
                                state     <= DIV_DONE;
                            end else begin
                                prem  <= '0;
                                dvd   <= a_abs;
                                dvs   <= b_abs;
                                neg_q <= a_neg ^ b_neg;
                                neg_r <= a_neg;
                                cnt   <= '0;
                                state <= DIV_CALC;
                            end
                        end
                    end
                    DIV_CALC: begin
                        prem <= prem_nxt;
                        dvd  <= dvd_nxt;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                            done      <= 1'b1;
                            state     <= DIV_DONE;
                        end
                    end
                    DIV_DONE: state <= DIV_IDLE;
                    default:  state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// back-to-back operations against a 64-bit arithmetic reference.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_req;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks   = 0;
    int failures = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .stall_req  (stall_req),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit integer division (truncating, remainder follows dividend).
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    input logic s, output logic [31:0] q,
                                    output logic [31:0] r);
        longint sx, sy;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
            return;
        end
        sx = s ? longint'($signed(x)) : longint'({32'd0, x});
        sy = s ? longint'($signed(y)) : longint'({32'd0, y});
        q  = 32'(sx / sy);
        r  = 32'(sx % sy);
    endfunction

    // Runs one operation; returns results, start-to-done latency and the
    // number of cycles where stall_req had the wrong level.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input int poke, output logic [31:0] q, output logic [31:0] r,
                         output int lat, output int stall_bad);
        stall_bad = 0;
        @(negedge clk);
        a = ia; b = ib; signed_div = is; start = 1'b1;
        #1 if (stall_req !== 1'b1) stall_bad++;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; signed_div = 1'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (stall_req !== 1'b1) stall_bad++;
            start = (lat == poke);
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (stall_req !== 1'b0) stall_bad++;
        q = quotient;
        r = remainder;
        @(posedge clk); #1;
        if (done !== 1'b0) stall_bad++;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        #12;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_req); end
        checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL reset_q got=%h want=0", quotient); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL reset_r got=%h want=0", remainder); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_unsigned;
        logic [31:0] q, r; int lat, sb;
        do_op(32'd100, 32'd7, 1'b0, -1, q, r, lat, sb);
        checks++; if (lat !== 33) begin failures++; $display("FAIL unsigned_lat got=%0d want=33", lat); end
        checks++; if (sb !== 0) begin failures++; $display("FAIL unsigned_stall bad_cycles=%0d want=0", sb); end
        checks++; if (q !== 32'd14) begin failures++; $display("FAIL unsigned_q got=%h want=e", q); end
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL unsigned_r got=%h want=2", r); end
    endtask

    task automatic test_signed;
        logic [31:0] q, r; int lat, sb;
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, q, r, lat, sb);
        checks++; if (q !== 32'hFFFF_FFFD) begin failures++; $display("FAIL signed1_q got=%h want=fffffffd", q); end
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL signed1_r got=%h want=ffffffff", r); end
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, q, r, lat, sb);
        checks++; if (q !== 32'hFFFF_FFFD) begin failures++; $display("FAIL signed2_q got=%h want=fffffffd", q); end
        checks++; if (r !== 32'd1) begin failures++; $display("FAIL signed2_r got=%h want=1", r); end
        checks++; if (sb !== 0) begin failures++; $display("FAIL signed_stall bad_cycles=%0d want=0", sb); end
    endtask

    task automatic test_extremes;
        logic [31:0] q, r; int lat, sb;
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, q, r, lat, sb);
        checks++; if (q !== 32'h8000_0000) begin failures++; $display("FAIL ovf_q got=%h want=80000000", q); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL ovf_r got=%h want=0", r); end
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, q, r, lat, sb);
        checks++; if (q !== 32'hFFFF_FFFF) begin failures++; $display("FAIL umax_q got=%h want=ffffffff", q); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL umax_r got=%h want=0", r); end
    endtask

    task automatic test_div_zero;
        logic [31:0] q, r; int lat, sb;
        do_op(32'd5, 32'd0, 1'b0, -1, q, r, lat, sb);
        checks++; if (lat !== 1) begin failures++; $display("FAIL dz_lat got=%0d want=1", lat); end
        checks++; if (sb !== 0) begin failures++; $display("FAIL dz_stall bad_cycles=%0d want=0", sb); end
        checks++; if (q !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_q got=%h want=ffffffff", q); end
        checks++; if (r !== 32'd5) begin failures++; $display("FAIL dz_r got=%h want=5", r); end
    endtask

    task automatic test_cancel;
        logic [31:0] q, r; int lat, sb, seen;
        do_op(32'd1000, 32'd10, 1'b0, -1, q, r, lat, sb);
        @(negedge clk); a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); cancel = 1'b1; start = 1'b1; a = 32'd55; b = 32'd5;
        @(posedge clk); #1 cancel = 1'b0; start = 1'b0;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL cancel_idle stall=%b want=0", stall_req); end
        checks++; if (quotient !== 32'd100) begin failures++; $display("FAIL cancel_q got=%h want=64", quotient); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL cancel_r got=%h want=0", remainder); end
        // start together with cancel in IDLE must also be refused
        @(negedge clk); cancel = 1'b1; start = 1'b1; a = 32'd8; b = 32'd2;
        #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL cancel_start_stall got=%b want=0", stall_req); end
        @(posedge clk); #1 cancel = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            if (done === 1'b1 || stall_req === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL cancel_no_done active_cycles=%0d want=0", seen); end
        checks++; if (quotient !== 32'd100) begin failures++; $display("FAIL cancel_hold_q got=%h want=64", quotient); end
        do_op(32'd9, 32'd3, 1'b0, -1, q, r, lat, sb);
        checks++; if (q !== 32'd3) begin failures++; $display("FAIL after_cancel_q got=%h want=3", q); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL after_cancel_r got=%h want=0", r); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL after_cancel_lat got=%0d want=33", lat); end
    endtask

    task automatic test_start_in_calc;
        logic [31:0] q, r; int lat, sb;
        do_op(32'd1000, 32'd7, 1'b0, 5, q, r, lat, sb);
        checks++; if (q !== 32'd142) begin failures++; $display("FAIL poke_q got=%h want=8e", q); end
        checks++; if (r !== 32'd6) begin failures++; $display("FAIL poke_r got=%h want=6", r); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL poke_lat got=%0d want=33", lat); end
    endtask

    task automatic test_async_reset;
        logic [31:0] q, r; int lat, sb;
        do_op(32'd100, 32'd7, 1'b0, -1, q, r, lat, sb);
        @(negedge clk); a = 32'd50; b = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL ares_pre_stall got=%b want=1", stall_req); end
        rst = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL ares_stall got=%b want=0", stall_req); end
        checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL ares_q got=%h want=0", quotient); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL ares_r got=%h want=0", remainder); end
        @(negedge clk); rst = 1'b0;
        // reset landing in the done cycle
        @(negedge clk); a = 32'd77; b = 32'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ares_dz_done got=%b want=1", done); end
        #1 rst = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ares_done got=%b want=0", done); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL ares_dz_r got=%h want=0", remainder); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] q, r, eq, er, x, y; logic s; int lat, sb, sel;
        for (int i = 0; i < 300; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            sel = $urandom_range(0, 9);
            case (sel)
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: y = 32'hFFFF_FFFF;
                3: x = 32'h8000_0000;
                4: y = y >> $urandom_range(1, 31);
                5: begin x = x >> $urandom_range(0, 31); y = -32'($urandom_range(1, 100)); end
                default: ;
            endcase
            ref_div(x, y, s, eq, er);
            do_op(x, y, s, -1, q, r, lat, sb);
            checks++; if (q !== eq || r !== er) begin failures++; $display("FAIL rand_%0d a=%h b=%h s=%b got q=%h r=%h want q=%h r=%h", i, x, y, s, q, r, eq, er); end
            checks++; if (lat !== ((y == 32'd0) ? 1 : 33) || sb !== 0) begin failures++; $display("FAIL rand_timing_%0d lat=%0d stall_bad=%0d b=%h", i, lat, sb, y); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_div_zero();
        test_cancel();
        test_start_in_calc();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
